// File: rtl/cu_pkg.sv
// Shared definitions for the decode stage: control bundle layout,
// opcode map, field encodings and the opcode decode function.
package cu_pkg;

   localparam logic [1:0] IT_NONE = 2'b00;
   localparam logic [1:0] IT_REG  = 2'b01;
   localparam logic [1:0] IT_IMM  = 2'b10;

   localparam logic [2:0] SRC_REG = 3'b000;
   localparam logic [2:0] SRC_IMM = 3'b001;

   localparam logic [5:0] OP_NOP        = 6'h00;
   localparam logic [5:0] OP_ADD        = 6'h01;
   localparam logic [5:0] OP_SUB        = 6'h02;
   localparam logic [5:0] OP_LAST_ARITH = 6'h08;
   localparam logic [5:0] OP_INV        = 6'h09;
   localparam logic [5:0] OP_LAST_REG   = 6'h0D;
   localparam logic [5:0] OP_LDIM       = 6'h0E;
   localparam logic [5:0] OP_ADDI       = 6'h0F;
   localparam logic [5:0] OP_IISUB      = 6'h1B;
   localparam logic [5:0] OP_LAST_LEGAL = 6'h1B;

   typedef struct packed {
      logic [1:0] inst_type;
      logic [1:0] wb_sel;
      logic [2:0] src_sel;
      logic [3:0] alu_sel;
      logic       alu_c_in;
      logic       alu_enable;
      logic       reg_read_a;
      logic       reg_read_b;
      logic       reg_write;
      logic       reg_reset;
   } ctrl_t;

   typedef struct packed {
      ctrl_t ctrl;
      logic  illegal;
   } decode_t;

   // Opcodes above the legal range (including any set bit above bit 5,
   // flagged by upper_nz) decode as a NOP bundle with the illegal bit set.
   function automatic decode_t decode(input logic [5:0] op, input logic upper_nz);
      decode_t d;
      d = '0;
      if (upper_nz || (op > OP_LAST_LEGAL)) begin
         d.illegal = 1'b1;
      end else if ((op >= OP_ADD) && (op <= OP_LAST_REG)) begin
         d.ctrl.inst_type  = IT_REG;
         d.ctrl.src_sel    = SRC_REG;
         d.ctrl.alu_enable = 1'b1;
         d.ctrl.reg_write  = 1'b1;
         d.ctrl.reg_read_a = 1'b1;
         d.ctrl.reg_read_b = (op != OP_INV);
         if (op == OP_INV) begin
            d.ctrl.alu_sel = 4'hC;
         end else if (op <= OP_LAST_ARITH) begin
            d.ctrl.alu_sel = 4'(op - 6'd1);
         end else begin
            d.ctrl.alu_sel = 4'(op - 6'd2);
         end
      end else if (op == OP_LDIM) begin
         d.ctrl.inst_type  = IT_IMM;
         d.ctrl.src_sel    = SRC_IMM;
         d.ctrl.alu_sel    = 4'h2;
         d.ctrl.alu_enable = 1'b1;
         d.ctrl.reg_write  = 1'b1;
      end else if (op >= OP_ADDI) begin
         d.ctrl.inst_type  = IT_IMM;
         d.ctrl.src_sel    = SRC_IMM;
         d.ctrl.alu_sel    = 4'(op - OP_ADDI);
         d.ctrl.alu_enable = 1'b1;
         d.ctrl.reg_write  = 1'b1;
         d.ctrl.reg_read_a = 1'b1;
      end
      return d;
   endfunction

endpackage

// File: rtl/cu_scoreboard.sv
// Write-back scoreboard: tracks destination registers of issued writes
// until the register file has committed them.
module cu_scoreboard #(
   parameter int WB_LAT     = 3,
   parameter int REG_ADDR_W = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push,
   input  logic [REG_ADDR_W-1:0] push_rd,
   input  logic                  qa_en,
   input  logic [REG_ADDR_W-1:0] qa,
   input  logic                  qb_en,
   input  logic [REG_ADDR_W-1:0] qb,
   output logic                  hit
);

   logic                  slot_v  [WB_LAT];
   logic [REG_ADDR_W-1:0] slot_rd [WB_LAT];

   // Shift the in-flight writes one slot per cycle; slot 0 takes the issuing write.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < WB_LAT; i++) begin
            slot_v[i] <= 1'b0;
         end
      end else begin
         slot_v[0]  <= push;
         slot_rd[0] <= push_rd;
         for (int i = 1; i < WB_LAT; i++) begin
            slot_v[i]  <= slot_v[i-1];
            slot_rd[i] <= slot_rd[i-1];
         end
      end
   end

   // The write issuing this cycle counts as pending; the last slot is the
   // write completing this cycle, so a reader accepted now already sees it.
   always_comb begin
      hit = push && ((qa_en && (qa == push_rd)) || (qb_en && (qb == push_rd)));
      for (int i = 0; i < WB_LAT - 1; i++) begin
         if (slot_v[i] && ((qa_en && (qa == slot_rd[i])) || (qb_en && (qb == slot_rd[i])))) begin
            hit = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cu_decode_pipe.sv
// Registered instruction-decode stage with valid/ready handshake,
// read-after-write stall and sticky illegal-opcode flag.
module cu_decode_pipe
   import cu_pkg::*;
#(
   parameter int OPCODE_W   = 6,
   parameter int REG_ADDR_W = 3,
   parameter int WB_LAT     = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [OPCODE_W-1:0]   in_opcode,
   input  logic [REG_ADDR_W-1:0] in_rd,
   input  logic [REG_ADDR_W-1:0] in_ra,
   input  logic [REG_ADDR_W-1:0] in_rb,
   output logic                  out_valid,
   input  logic                  out_ready,
   output ctrl_t                 out_ctrl,
   output logic [REG_ADDR_W-1:0] out_rd,
   output logic [REG_ADDR_W-1:0] out_ra,
   output logic [REG_ADDR_W-1:0] out_rb,
   output logic                  illegal_err
);

   logic    upper_nz;
   decode_t dec;
   logic    issue;
   logic    accept;
   logic    sb_hit;
   logic    out_hit;
   logic    hazard;

   assign upper_nz = (in_opcode >> 6) != '0;
   assign dec      = decode(in_opcode[5:0], upper_nz);
   assign issue    = out_valid && out_ready;

   assign out_hit = out_valid && out_ctrl.reg_write && !issue &&
                    ((dec.ctrl.reg_read_a && (in_ra == out_rd)) ||
                     (dec.ctrl.reg_read_b && (in_rb == out_rd)));
   assign hazard   = sb_hit || out_hit;
   assign in_ready = rst_n && !flush && !hazard && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;

   cu_scoreboard #(
      .WB_LAT     (WB_LAT),
      .REG_ADDR_W (REG_ADDR_W)
   ) u_scoreboard (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (issue && out_ctrl.reg_write),
      .push_rd (out_rd),
      .qa_en   (dec.ctrl.reg_read_a),
      .qa      (in_ra),
      .qb_en   (dec.ctrl.reg_read_b),
      .qb      (in_rb),
      .hit     (sb_hit)
   );

   // Output register: load on accept, empty on issue, flush kills the bundle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_ctrl  <= '0;
         out_rd    <= '0;
         out_ra    <= '0;
         out_rb    <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_ctrl  <= dec.ctrl;
         out_rd    <= in_rd;
         out_ra    <= in_ra;
         out_rb    <= in_rb;
      end else if (issue) begin
         out_valid <= 1'b0;
      end
   end

   // Sticky flag raised when an illegal opcode is taken in.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         illegal_err <= 1'b0;
      end else if (accept && dec.illegal) begin
         illegal_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_cu_decode_pipe.sv
// Directed self-checking bench for cu_decode_pipe (default parameters).
module tb_cu_decode_pipe;
   import cu_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [5:0]  in_opcode;
   logic [2:0]  in_rd;
   logic [2:0]  in_ra;
   logic [2:0]  in_rb;
   logic        out_valid;
   logic        out_ready;
   ctrl_t       out_ctrl;
   logic [2:0]  out_rd;
   logic [2:0]  out_ra;
   logic [2:0]  out_rb;
   logic        illegal_err;

   int compared;
   int mismatched;

   cu_decode_pipe #(
      .OPCODE_W   (6),
      .REG_ADDR_W (3),
      .WB_LAT     (3)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_opcode   (in_opcode),
      .in_rd       (in_rd),
      .in_ra       (in_ra),
      .in_rb       (in_rb),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_ctrl    (out_ctrl),
      .out_rd      (out_rd),
      .out_ra      (out_ra),
      .out_rb      (out_rb),
      .illegal_err (illegal_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected bundle built from the field list: inst_type, wb_sel=0, src_sel,
   // alu_sel, alu_c_in=0, alu_enable, reg_read_a, reg_read_b, reg_write, reg_reset=0.
   function automatic logic [16:0] mkCtrl(input logic [1:0] it, input logic [2:0] src,
                                          input logic [3:0] alu, input logic en,
                                          input logic ra, input logic rb, input logic rw);
      return {it, 2'b00, src, alu, 1'b0, en, ra, rb, rw, 1'b0};
   endfunction

   localparam logic [16:0] C_ADD   = 17'h0801E;
   localparam logic [16:0] C_NOP   = 17'h00000;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic v, input logic [5:0] op, input logic [2:0] rd,
                                input logic [2:0] ra, input logic [2:0] rb);
      in_valid  = v;
      in_opcode = op;
      in_rd     = rd;
      in_ra     = ra;
      in_rb     = rb;
      #1;
   endtask

   task automatic drain();
      applyStimulus(1'b0, 6'h00, 3'd0, 3'd0, 3'd0);
      for (int i = 0; i < 5; i++) step();
   endtask

   // Steps until in_ready rises; returns the number of cycles waited.
   task automatic waitReady(input int limit, output int waited);
      waited = 0;
      while (!in_ready && waited < limit) begin
         step();
         waited++;
      end
   endtask

   initial begin
      int waited;
      compared   = 0;
      mismatched = 0;
      rst_n      = 1'b0;
      flush      = 1'b0;
      out_ready  = 1'b0;
      applyStimulus(1'b0, 6'h00, 3'd0, 3'd0, 3'd0);
      step();
      step();
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_out_ctrl", 32'(out_ctrl), 32'(C_NOP));
      checkOutput("rst_illegal", 32'(illegal_err), 32'd0);
      checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
      rst_n     = 1'b1;
      out_ready = 1'b1;

      // ADD then IISUB back-to-back
      applyStimulus(1'b1, 6'h01, 3'd2, 3'd0, 3'd1);
      checkOutput("add_in_ready", 32'(in_ready), 32'd1);
      step();
      applyStimulus(1'b1, 6'h1B, 3'd4, 3'd5, 3'd6);
      checkOutput("add_valid", 32'(out_valid), 32'd1);
      checkOutput("add_ctrl", 32'(out_ctrl), 32'(C_ADD));
      checkOutput("add_ctrl_fields", 32'(out_ctrl), 32'(mkCtrl(2'b01, 3'b000, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1)));
      checkOutput("add_regs", 32'({out_rd, out_ra, out_rb}), 32'({3'd2, 3'd0, 3'd1}));
      checkOutput("iisub_in_ready", 32'(in_ready), 32'd1);
      step();
      checkOutput("iisub_ctrl", 32'(out_ctrl), 32'(mkCtrl(2'b10, 3'b001, 4'hC, 1'b1, 1'b1, 1'b0, 1'b1)));
      checkOutput("iisub_rd", 32'(out_rd), 32'd4);
      drain();

      // ADDI rd=3 then SUB reading r3: held exactly WB_LAT cycles from ADDI issue
      applyStimulus(1'b1, 6'h0F, 3'd3, 3'd0, 3'd0);
      step();
      applyStimulus(1'b1, 6'h02, 3'd5, 3'd3, 3'd1);
      checkOutput("addi_ctrl", 32'(out_ctrl), 32'(mkCtrl(2'b10, 3'b001, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1)));
      checkOutput("raw_stall_issue_cycle", 32'(in_ready), 32'd0);
      waitReady(10, waited);
      checkOutput("raw_wait_cycles", 32'(waited), 32'd3);
      step();
      checkOutput("sub_ctrl", 32'(out_ctrl), 32'(mkCtrl(2'b01, 3'b000, 4'h1, 1'b1, 1'b1, 1'b1, 1'b1)));
      checkOutput("sub_ra", 32'(out_ra), 32'd3);
      drain();

      // ADDI rd=3 then LDIM (no reads) goes straight through
      applyStimulus(1'b1, 6'h0F, 3'd3, 3'd0, 3'd0);
      step();
      applyStimulus(1'b1, 6'h0E, 3'd6, 3'd3, 3'd3);
      checkOutput("ldim_in_ready", 32'(in_ready), 32'd1);
      step();
      checkOutput("ldim_ctrl", 32'(out_ctrl), 32'(mkCtrl(2'b10, 3'b001, 4'h2, 1'b1, 1'b0, 1'b0, 1'b1)));
      drain();

      // Backpressure: XOR held for 4 cycles, then issue with INV accepted same cycle
      out_ready = 1'b0;
      applyStimulus(1'b1, 6'h0A, 3'd1, 3'd2, 3'd3);
      step();
      applyStimulus(1'b1, 6'h09, 3'd7, 3'd4, 3'd0);
      for (int i = 0; i < 4; i++) begin
         checkOutput("bp_valid", 32'(out_valid), 32'd1);
         checkOutput("bp_ctrl", 32'(out_ctrl), 32'(mkCtrl(2'b01, 3'b000, 4'h8, 1'b1, 1'b1, 1'b1, 1'b1)));
         checkOutput("bp_rd", 32'(out_rd), 32'd1);
         checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
         step();
      end
      out_ready = 1'b1;
      #1;
      checkOutput("bp_release_ready", 32'(in_ready), 32'd1);
      step();
      checkOutput("inv_valid", 32'(out_valid), 32'd1);
      checkOutput("inv_ctrl", 32'(out_ctrl), 32'(mkCtrl(2'b01, 3'b000, 4'hC, 1'b1, 1'b1, 1'b0, 1'b1)));
      checkOutput("inv_rd", 32'(out_rd), 32'd7);
      drain();

      // Illegal opcode 0x2A: NOP bundle, sticky error
      applyStimulus(1'b1, 6'h2A, 3'd2, 3'd1, 3'd1);
      checkOutput("ill_before", 32'(illegal_err), 32'd0);
      step();
      applyStimulus(1'b0, 6'h00, 3'd0, 3'd0, 3'd0);
      checkOutput("ill_valid", 32'(out_valid), 32'd1);
      checkOutput("ill_ctrl", 32'(out_ctrl), 32'(C_NOP));
      checkOutput("ill_err", 32'(illegal_err), 32'd1);
      step();
      step();
      checkOutput("ill_sticky", 32'(illegal_err), 32'd1);
      drain();

      // Flush during issue of ADDI rd=5: input rejected, write still tracked
      applyStimulus(1'b1, 6'h0F, 3'd5, 3'd0, 3'd0);
      step();
      flush = 1'b1;
      applyStimulus(1'b1, 6'h0E, 3'd6, 3'd0, 3'd0);
      checkOutput("flush_in_ready", 32'(in_ready), 32'd0);
      step();
      flush = 1'b0;
      applyStimulus(1'b1, 6'h02, 3'd1, 3'd5, 3'd0);
      checkOutput("flush_out_valid", 32'(out_valid), 32'd0);
      checkOutput("flush_stall", 32'(in_ready), 32'd0);
      waitReady(10, waited);
      checkOutput("flush_wait_cycles", 32'(waited), 32'd2);
      step();
      checkOutput("flush_sub_ra", 32'(out_ra), 32'd5);
      checkOutput("flush_illegal_kept", 32'(illegal_err), 32'd1);
      drain();

      // Reset during a hazard stall
      applyStimulus(1'b1, 6'h0F, 3'd4, 3'd0, 3'd0);
      step();
      applyStimulus(1'b1, 6'h02, 3'd2, 3'd4, 3'd0);
      checkOutput("rs_stall0", 32'(in_ready), 32'd0);
      step();
      checkOutput("rs_stall1", 32'(in_ready), 32'd0);
      rst_n = 1'b0;
      #1;
      checkOutput("rs_in_ready_low", 32'(in_ready), 32'd0);
      step();
      checkOutput("rs_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rs_out_ctrl", 32'(out_ctrl), 32'(C_NOP));
      checkOutput("rs_out_regs", 32'({out_rd, out_ra, out_rb}), 32'd0);
      checkOutput("rs_illegal", 32'(illegal_err), 32'd0);
      rst_n = 1'b1;
      #1;
      checkOutput("rs_release_ready", 32'(in_ready), 32'd1);
      step();
      checkOutput("rs_sub_valid", 32'(out_valid), 32'd1);
      checkOutput("rs_sub_ra", 32'(out_ra), 32'd4);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL timeout: simulation did not finish");
      $fatal(1, "[TB] timeout");
   end

endmodule
